// File: rtl/vector_mem_arbiter_pkg.sv
// Shared types and defaults for the vector memory arbiter.
//   request_t : request/response beat exchanged with load/store units and memory
//   ARB_NUM_REQ_DEFAULT / ARB_MAX_OUTSTANDING_DEFAULT : default arbiter sizing
package vector_mem_arbiter_pkg;

  localparam int ARB_NUM_REQ_DEFAULT         = 4;
  localparam int ARB_MAX_OUTSTANDING_DEFAULT = 16;

  typedef struct packed {
    logic        vld;
    logic        we;
    logic [3:0]  access_id;
    logic [31:0] addr;
    logic [31:0] data;
  } request_t;

endpackage

// File: rtl/vector_mem_arbiter_arb_src_fifo.sv
// Synchronous FIFO holding the source index of each outstanding memory request,
// so in-order responses can be steered back to the unit that issued them.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   push, push_data  : enqueue a source index (ignored when full)
//   pop, head        : dequeue / current head entry (pop ignored when empty)
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..DEPTH)
module arb_src_fifo #(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers (wrap naturally, depth is a power of two) and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among NUM_REQ
// vector load/store units. Issued source indices are queued so in-order
// memory responses are routed back to their owner one cycle after arrival.
// Optional build macro: ARB_PERF_CNT_EN adds grant/stall performance counters.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   lsu_req         : per-unit request, vld held until granted
//   lsu_grant       : one-hot, combinational, marks the captured unit
//   lsu_rsp         : registered per-unit response
//   mem_req         : registered request to memory
//   mem_grant       : memory accepts mem_req this cycle
//   mem_rsp         : memory response, returned in issue order
//   mem_rsp_ack     : response consumed (valid and something outstanding)
//   perf_grant_cnt  : (ARB_PERF_CNT_EN) per-unit saturating grant counts
//   perf_full_stall : (ARB_PERF_CNT_EN) cycles stalled only by a full FIFO
//   rsp_err         : sticky, response seen with nothing outstanding
module vector_mem_arbiter
  import vector_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = ARB_NUM_REQ_DEFAULT,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING_DEFAULT,
  parameter int SRC_W           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  request_t [NUM_REQ-1:0]    lsu_req,
  output logic     [NUM_REQ-1:0]    lsu_grant,
  output request_t [NUM_REQ-1:0]    lsu_rsp,
  output request_t                  mem_req,
  input  logic                      mem_grant,
  input  request_t                  mem_rsp,
  output logic                      mem_rsp_ack,
`ifdef ARB_PERF_CNT_EN
  output logic [NUM_REQ-1:0][31:0]  perf_grant_cnt,
  output logic [31:0]               perf_full_stall,
`endif
  output logic                      rsp_err
);

  localparam int               CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W + 1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);
  localparam logic [SRC_W-1:0] IDX_ONE   = SRC_W'(1'b1);

  logic [SRC_W-1:0] rr_ptr_r;
  logic [SRC_W-1:0] winner_s;
  logic [SRC_W:0]   cand_s;
  logic             found_s;
  logic             slot_free_s;
  logic             grant_vld_s;
  logic             pop_s;
  logic [SRC_W-1:0] fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;

  // A new request may be captured when the output slot drains this cycle and
  // the routing FIFO has room; a same-cycle pop deliberately does not count.
  assign slot_free_s = !mem_req.vld || mem_grant;
  assign grant_vld_s = slot_free_s && !fifo_full_s && found_s;
  assign pop_s       = mem_rsp.vld && !fifo_empty_s;
  assign mem_rsp_ack = pop_s;

  // Round-robin pick: first valid unit at or after rr_ptr, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (SRC_W + 1)'(k);
      if (cand_s >= NUM_REQ_W) begin
        cand_s = cand_s - NUM_REQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && lsu_req[cand_s[SRC_W-1:0]].vld) begin
        found_s  = 1'b1;
        winner_s = cand_s[SRC_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // One-hot grant to the captured unit.
  always_comb begin
    lsu_grant = '0;
    if (grant_vld_s) begin
      lsu_grant[winner_s] = 1'b1;
    end else begin
      lsu_grant = '0;
    end
  end

  // Output request register and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req  <= '0;
      rr_ptr_r <= '0;
    end else if (grant_vld_s) begin
      mem_req     <= lsu_req[winner_s];
      mem_req.vld <= 1'b1;
      rr_ptr_r    <= (winner_s == LAST_IDX) ? '0 : winner_s + IDX_ONE;
    end else if (slot_free_s) begin
      mem_req.vld <= 1'b0;
    end
  end

  // Response routing: the FIFO head names the owner of each in-order response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lsu_rsp <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pop_s && (fifo_head_s == SRC_W'(i))) begin
          lsu_rsp[i]     <= mem_rsp;
          lsu_rsp[i].vld <= 1'b1;
        end else begin
          lsu_rsp[i].vld <= 1'b0;
        end
      end
    end
  end

  // Sticky error for a response that has no outstanding request to match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err <= 1'b0;
    end else if (mem_rsp.vld && (fifo_count_s == '0)) begin
      rsp_err <= 1'b1;
    end
  end

  arb_src_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (SRC_W)
  ) u_src_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant_vld_s),
    .push_data (winner_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

`ifdef ARB_PERF_CNT_EN
  logic any_req_s;

  // Any unit currently requesting.
  always_comb begin
    any_req_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      any_req_s = any_req_s | lsu_req[i].vld;
    end
  end

  // Per-unit grant counters, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (lsu_grant[i] && (perf_grant_cnt[i] != 32'hFFFF_FFFF)) begin
          perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Cycles where only the outstanding cap blocks a pending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_full_stall <= '0;
    end else if (slot_free_s && any_req_s && fifo_full_s &&
                 (perf_full_stall != 32'hFFFF_FFFF)) begin
      perf_full_stall <= perf_full_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_mem_arbiter.sv
module tb_vector_mem_arbiter;
  import vector_mem_arbiter_pkg::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               reset;
  request_t [N-1:0]   lsu_req;
  logic     [N-1:0]   lsu_grant;
  request_t [N-1:0]   lsu_rsp;
  request_t           mem_req;
  logic               mem_grant;
  request_t           mem_rsp;
  logic               mem_rsp_ack;
  logic               rsp_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] addr;
    logic        mg;
    logic        rv;
    logic [3:0]  rid;
    logic [3:0]  e_grant;
    logic        e_ack;
    logic        e_mvld;
    logic [31:0] e_maddr;
    logic [3:0]  e_rvld;
    logic [3:0]  e_rid;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  vector_mem_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lsu_req     (lsu_req),
    .lsu_grant   (lsu_grant),
    .lsu_rsp     (lsu_rsp),
    .mem_req     (mem_req),
    .mem_grant   (mem_grant),
    .mem_rsp     (mem_rsp),
    .mem_rsp_ack (mem_rsp_ack),
    .rsp_err     (rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rsp_mask();
    logic [3:0] m;
    for (int i = 0; i < N; i++) m[i] = lsu_rsp[i].vld;
    return m;
  endfunction

  // Unit i presents addr + i*0x1000 with access_id i.
  task automatic drive(input logic [3:0] vld, input logic [31:0] addr, input logic mg,
                       input logic rv, input logic [3:0] rid);
    for (int i = 0; i < N; i++) begin
      lsu_req[i]           = '0;
      lsu_req[i].vld       = vld[i];
      lsu_req[i].addr      = addr + 32'(i) * 32'h0000_1000;
      lsu_req[i].access_id = 4'(i);
    end
    mem_grant           = mg;
    mem_rsp             = '0;
    mem_rsp.vld         = rv;
    mem_rsp.access_id   = rid;
    mem_rsp.addr        = 32'h0000_A000 + 32'(rid);
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.vld, v.addr, v.mg, v.rv, v.rid);
    #1;
    chk($sformatf("grant[%0d]", idx), 32'(lsu_grant), 32'(v.e_grant));
    chk($sformatf("ack[%0d]", idx), 32'(mem_rsp_ack), 32'(v.e_ack));
    tick();
    chk($sformatf("mem_vld[%0d]", idx), 32'(mem_req.vld), 32'(v.e_mvld));
    if (v.e_mvld) chk($sformatf("mem_addr[%0d]", idx), mem_req.addr, v.e_maddr);
    chk($sformatf("rsp_vld[%0d]", idx), 32'(rsp_mask()), 32'(v.e_rvld));
    for (int i = 0; i < N; i++) begin
      if (v.e_rvld[i]) chk($sformatf("rsp_id[%0d]", idx), 32'(lsu_rsp[i].access_id), 32'(v.e_rid));
    end
    chk($sformatf("rsp_err[%0d]", idx), 32'(rsp_err), 32'd0);
  endtask

  initial begin
    // all four units continuously: 0,1,2,3,0,1 then pointer wraps
    vt.push_back('{4'b1111, 32'h200, 1'b1, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b1, 32'h0000_0200, 4'b0000, 4'd0});
    vt.push_back('{4'b1111, 32'h200, 1'b1, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b1, 32'h0000_1200, 4'b0000, 4'd0});
    vt.push_back('{4'b1111, 32'h200, 1'b1, 1'b0, 4'd0, 4'b0100, 1'b0, 1'b1, 32'h0000_2200, 4'b0000, 4'd0});
    vt.push_back('{4'b1111, 32'h200, 1'b1, 1'b0, 4'd0, 4'b1000, 1'b0, 1'b1, 32'h0000_3200, 4'b0000, 4'd0});
    vt.push_back('{4'b1111, 32'h200, 1'b1, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b1, 32'h0000_0200, 4'b0000, 4'd0});
    vt.push_back('{4'b1111, 32'h200, 1'b1, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b1, 32'h0000_1200, 4'b0000, 4'd0});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'd0});
    // drain six in-order responses
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd1, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0001, 4'd1});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd2, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0010, 4'd2});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd3, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0100, 4'd3});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd4, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b1000, 4'd4});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd5, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0001, 4'd5});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd6, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0010, 4'd6});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'd0});
    // single unit 1, two back-to-back requests
    vt.push_back('{4'b0010, 32'h100, 1'b1, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b1, 32'h0000_1100, 4'b0000, 4'd0});
    vt.push_back('{4'b0010, 32'h108, 1'b1, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b1, 32'h0000_1108, 4'b0000, 4'd0});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'd0});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd5, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0010, 4'd5});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd6, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0010, 4'd6});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'd0});
    // units 2,0,3 then 1 issued alongside the first response
    vt.push_back('{4'b0100, 32'h300, 1'b1, 1'b0, 4'd0, 4'b0100, 1'b0, 1'b1, 32'h0000_2300, 4'b0000, 4'd0});
    vt.push_back('{4'b0001, 32'h300, 1'b1, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b1, 32'h0000_0300, 4'b0000, 4'd0});
    vt.push_back('{4'b1000, 32'h300, 1'b1, 1'b0, 4'd0, 4'b1000, 1'b0, 1'b1, 32'h0000_3300, 4'b0000, 4'd0});
    vt.push_back('{4'b0010, 32'h300, 1'b1, 1'b1, 4'd5, 4'b0010, 1'b1, 1'b1, 32'h0000_1300, 4'b0100, 4'd5});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd6, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0001, 4'd6});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd7, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b1000, 4'd7});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b1, 4'd8, 4'b0000, 1'b1, 1'b0, 32'h0, 4'b0010, 4'd8});
    vt.push_back('{4'b0000, 32'h000, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'd0});

    reset = 1'b1;
    drive(4'b0000, 32'h0, 1'b0, 1'b0, 4'd0);
    #2 reset = 1'b0;
    tick();
    tick();
    chk("reset_mem_req", 32'(mem_req != '0), 32'd0);
    chk("reset_lsu_rsp", 32'(lsu_rsp != '0), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_grant", 32'(lsu_grant), 32'd0);
    reset = 1'b1;

    for (int n = 0; n < vt.size(); n++) apply(vt[n], n);

    // mem_grant held low for five cycles while mem_req is valid
    drive(4'b0001, 32'h400, 1'b0, 1'b0, 4'd0);
    #1 chk("stall_first_grant", 32'(lsu_grant), 32'b0001);
    tick();
    chk("stall_first_addr", mem_req.addr, 32'h0000_0400);
    drive(4'b0010, 32'h400, 1'b0, 1'b0, 4'd0);
    for (int n = 0; n < 5; n++) begin
      #1 chk("stall_no_grant", 32'(lsu_grant), 32'd0);
      tick();
      chk("stall_hold_vld", 32'(mem_req.vld), 32'd1);
      chk("stall_hold_addr", mem_req.addr, 32'h0000_0400);
    end
    mem_grant = 1'b1;
    #1 chk("stall_release_grant", 32'(lsu_grant), 32'b0010);
    tick();
    chk("stall_release_addr", mem_req.addr, 32'h0000_1400);
    drive(4'b0000, 32'h0, 1'b1, 1'b0, 4'd0);
    tick();
    chk("stall_idle_vld", 32'(mem_req.vld), 32'd0);
    drive(4'b0000, 32'h0, 1'b1, 1'b1, 4'd1);
    tick();
    chk("stall_rsp0", 32'(rsp_mask()), 32'b0001);
    drive(4'b0000, 32'h0, 1'b1, 1'b1, 4'd2);
    tick();
    chk("stall_rsp1", 32'(rsp_mask()), 32'b0010);

    // sixteen outstanding grants fill the routing FIFO
    drive(4'b1111, 32'h500, 1'b1, 1'b0, 4'd0);
    for (int n = 0; n < 16; n++) begin
      logic [3:0] e;
      e = 4'b0001 << ((n + 2) % 4);
      #1 chk("fill_grant", 32'(lsu_grant), 32'(e));
      tick();
    end
    #1 chk("full_no_grant", 32'(lsu_grant), 32'd0);
    tick();
    chk("full_mem_idle", 32'(mem_req.vld), 32'd0);
    drive(4'b1111, 32'h500, 1'b1, 1'b1, 4'd3);
    #1 chk("full_pop_no_grant", 32'(lsu_grant), 32'd0);
    chk("full_pop_ack", 32'(mem_rsp_ack), 32'd1);
    tick();
    chk("full_pop_route", 32'(rsp_mask()), 32'b0100);
    chk("full_pop_id", 32'(lsu_rsp[2].access_id), 32'd3);
    drive(4'b1111, 32'h500, 1'b1, 1'b0, 4'd0);
    #1 chk("full_resume_grant", 32'(lsu_grant), 32'b0100);
    tick();
    drive(4'b0000, 32'h0, 1'b1, 1'b0, 4'd0);
    tick();

    // reset, then a response with nothing outstanding
    reset = 1'b0;
    #1 chk("rst1_mem_req", 32'(mem_req != '0), 32'd0);
    tick();
    reset = 1'b1;
    drive(4'b0000, 32'h0, 1'b1, 1'b1, 4'd4);
    #1 chk("err_no_ack", 32'(mem_rsp_ack), 32'd0);
    tick();
    chk("err_set", 32'(rsp_err), 32'd1);
    chk("err_no_rsp", 32'(rsp_mask()), 32'd0);
    drive(4'b0000, 32'h0, 1'b1, 1'b0, 4'd0);
    tick();
    chk("err_sticky", 32'(rsp_err), 32'd1);

    // three outstanding, then reset mid-operation
    drive(4'b0111, 32'h600, 1'b1, 1'b0, 4'd0);
    #1 chk("pre_rst_grant", 32'(lsu_grant), 32'b0001);
    tick();
    tick();
    tick();
    drive(4'b0000, 32'h0, 1'b1, 1'b0, 4'd0);
    chk("pre_rst_mem_vld", 32'(mem_req.vld), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst2_mem_req", 32'(mem_req != '0), 32'd0);
    chk("rst2_lsu_rsp", 32'(lsu_rsp != '0), 32'd0);
    chk("rst2_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst2_grant", 32'(lsu_grant), 32'd0);
    tick();
    reset = 1'b1;
    drive(4'b0000, 32'h0, 1'b1, 1'b1, 4'd9);
    #1 chk("late_rsp_no_ack", 32'(mem_rsp_ack), 32'd0);
    tick();
    chk("late_rsp_err", 32'(rsp_err), 32'd1);
    chk("late_rsp_no_route", 32'(rsp_mask()), 32'd0);
    drive(4'b0000, 32'h0, 1'b1, 1'b0, 4'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
